// File: rtl/objectbuffer_overlay.sv
// Draws one filled (or 50% blended) rectangle onto an AXI4-Stream video path.
// Object registers are shadowed at start-of-frame so register writes never tear a frame.
module objectbuffer_overlay #(
    parameter int DATA_W             = 24,
    parameter int COORD_W            = 12,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] obj_reg0,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] obj_reg1,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] obj_reg2,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] obj_reg3,
    input  logic [DATA_W-1:0]             s_axis_tdata,
    input  logic                          s_axis_tuser,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [DATA_W-1:0]             m_axis_tdata,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [15:0]                   frame_cnt
);

    localparam int NCH = DATA_W / 8;

    logic [COORD_W-1:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d, sh_w_q, sh_w_d, sh_h_q, sh_h_d;
    logic [DATA_W-1:0]  sh_col_q, sh_col_d;
    logic               sh_en_q, sh_en_d, sh_bl_q, sh_bl_d;
    logic [COORD_W-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;

    logic               v1_q, v1_d, user1_q, user1_d, last1_q, last1_d;
    logic               hit1_q, hit1_d, blend1_q, blend1_d;
    logic [DATA_W-1:0]  pix1_q, pix1_d, col1_q, col1_d;

    logic               v2_q, v2_d, user2_q, user2_d, last2_q, last2_d;
    logic [DATA_W-1:0]  pix2_q, pix2_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;

    logic               ce, acc;
    logic [COORD_W-1:0] eff_x, eff_y, eff_w, eff_h, cur_x, cur_y;
    logic [DATA_W-1:0]  eff_col, out_pix;
    logic               eff_en, eff_bl, hit;
    logic [COORD_W:0]   x_end, y_end;
    logic [8:0]         sum9;

    logic unused_bits;
    assign unused_bits = ^{obj_reg0[C_S_AXI_DATA_WIDTH-1:16+COORD_W], obj_reg0[15:COORD_W],
                           obj_reg1[C_S_AXI_DATA_WIDTH-1:16+COORD_W], obj_reg1[15:COORD_W],
                           obj_reg2[C_S_AXI_DATA_WIDTH-1:DATA_W], obj_reg3[C_S_AXI_DATA_WIDTH-1:2]};

    assign ce            = m_axis_tready || !v2_q;
    assign acc           = s_axis_tvalid && ce;
    assign s_axis_tready = ce;

    assign m_axis_tvalid = v2_q;
    assign m_axis_tdata  = pix2_q;
    assign m_axis_tuser  = user2_q;
    assign m_axis_tlast  = last2_q;
    assign frame_cnt     = frame_cnt_q;

    // The SOF beat itself is judged against the live registers it is about to latch.
    always_comb begin
        eff_x   = s_axis_tuser ? obj_reg0[COORD_W-1:0]       : sh_x_q;
        eff_y   = s_axis_tuser ? obj_reg0[16+COORD_W-1:16]   : sh_y_q;
        eff_w   = s_axis_tuser ? obj_reg1[COORD_W-1:0]       : sh_w_q;
        eff_h   = s_axis_tuser ? obj_reg1[16+COORD_W-1:16]   : sh_h_q;
        eff_col = s_axis_tuser ? obj_reg2[DATA_W-1:0]        : sh_col_q;
        eff_en  = s_axis_tuser ? obj_reg3[0]                 : sh_en_q;
        eff_bl  = s_axis_tuser ? obj_reg3[1]                 : sh_bl_q;
        cur_x   = s_axis_tuser ? '0 : x_cnt_q;
        cur_y   = s_axis_tuser ? '0 : y_cnt_q;
        x_end   = {1'b0, eff_x} + {1'b0, eff_w};
        y_end   = {1'b0, eff_y} + {1'b0, eff_h};
        hit     = eff_en && (cur_x >= eff_x) && ({1'b0, cur_x} < x_end)
                         && (cur_y >= eff_y) && ({1'b0, cur_y} < y_end);
    end

    always_comb begin
        sum9    = '0;
        out_pix = pix1_q;
        if (hit1_q) begin
            if (blend1_q) begin
                for (int c = 0; c < NCH; c++) begin
                    sum9 = {1'b0, pix1_q[c*8 +: 8]} + {1'b0, col1_q[c*8 +: 8]};
                    out_pix[c*8 +: 8] = sum9[8:1];
                end
            end else begin
                out_pix = col1_q;
            end
        end
    end

    always_comb begin
        sh_x_d   = sh_x_q;
        sh_y_d   = sh_y_q;
        sh_w_d   = sh_w_q;
        sh_h_d   = sh_h_q;
        sh_col_d = sh_col_q;
        sh_en_d  = sh_en_q;
        sh_bl_d  = sh_bl_q;
        x_cnt_d  = x_cnt_q;
        y_cnt_d  = y_cnt_q;
        v1_d     = v1_q;
        user1_d  = user1_q;
        last1_d  = last1_q;
        hit1_d   = hit1_q;
        blend1_d = blend1_q;
        pix1_d   = pix1_q;
        col1_d   = col1_q;
        v2_d     = v2_q;
        user2_d  = user2_q;
        last2_d  = last2_q;
        pix2_d   = pix2_q;
        frame_cnt_d = frame_cnt_q;

        if (acc) begin
            if (s_axis_tuser) begin
                sh_x_d   = eff_x;
                sh_y_d   = eff_y;
                sh_w_d   = eff_w;
                sh_h_d   = eff_h;
                sh_col_d = eff_col;
                sh_en_d  = eff_en;
                sh_bl_d  = eff_bl;
            end
            if (s_axis_tlast) begin
                x_cnt_d = '0;
                y_cnt_d = cur_y + COORD_W'(1);
            end else begin
                x_cnt_d = cur_x + COORD_W'(1);
                y_cnt_d = cur_y;
            end
        end

        if (ce) begin
            v1_d     = s_axis_tvalid;
            user1_d  = s_axis_tuser;
            last1_d  = s_axis_tlast;
            hit1_d   = hit;
            blend1_d = eff_bl;
            pix1_d   = s_axis_tdata;
            col1_d   = eff_col;
            v2_d     = v1_q;
            user2_d  = user1_q;
            last2_d  = last1_q;
            pix2_d   = out_pix;
        end

        if (v2_q && m_axis_tready && user2_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            sh_x_q      <= '0;
            sh_y_q      <= '0;
            sh_w_q      <= '0;
            sh_h_q      <= '0;
            sh_col_q    <= '0;
            sh_en_q     <= 1'b0;
            sh_bl_q     <= 1'b0;
            x_cnt_q     <= '0;
            y_cnt_q     <= '0;
            v1_q        <= 1'b0;
            user1_q     <= 1'b0;
            last1_q     <= 1'b0;
            hit1_q      <= 1'b0;
            blend1_q    <= 1'b0;
            pix1_q      <= '0;
            col1_q      <= '0;
            v2_q        <= 1'b0;
            user2_q     <= 1'b0;
            last2_q     <= 1'b0;
            pix2_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            sh_x_q      <= sh_x_d;
            sh_y_q      <= sh_y_d;
            sh_w_q      <= sh_w_d;
            sh_h_q      <= sh_h_d;
            sh_col_q    <= sh_col_d;
            sh_en_q     <= sh_en_d;
            sh_bl_q     <= sh_bl_d;
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
            v1_q        <= v1_d;
            user1_q     <= user1_d;
            last1_q     <= last1_d;
            hit1_q      <= hit1_d;
            blend1_q    <= blend1_d;
            pix1_q      <= pix1_d;
            col1_q      <= col1_d;
            v2_q        <= v2_d;
            user2_q     <= user2_d;
            last2_q     <= last2_d;
            pix2_q      <= pix2_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_objectbuffer_overlay.sv
// Bench for objectbuffer_overlay: directed frames plus random pixels/backpressure,
// scored against a per-beat rectangle model with a queue of expected output beats.
module tb_objectbuffer_overlay;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] obj_reg0, obj_reg1, obj_reg2, obj_reg3;
    logic [23:0] s_axis_tdata;
    logic        s_axis_tuser, s_axis_tlast, s_axis_tvalid, s_axis_tready;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tuser, m_axis_tlast, m_axis_tvalid, m_axis_tready;
    logic [15:0] frame_cnt;

    objectbuffer_overlay dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .obj_reg0(obj_reg0), .obj_reg1(obj_reg1), .obj_reg2(obj_reg2), .obj_reg3(obj_reg3),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .frame_cnt(frame_cnt)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [23:0] d;
        logic        u;
        logic        l;
        int          acc;
    } beat_t;

    beat_t       exp_q[$];
    int          n_cmp = 0, n_err = 0, cyc = 0, fc = 0;
    logic [31:0] sh0 = 0, sh1 = 0, sh2 = 0, sh3 = 0;
    int          mx = 0, my = 0;
    int          rdy_pct = 100;
    bit          strict_lat = 1'b0;
    logic [23:0] count_col = 24'h0;
    int          n_col = 0;
    bit          held_v = 1'b0;
    logic [25:0] held;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: rectangle membership and colour rule applied to one accepted beat.
    task automatic model_accept();
        int cx, cy, rx, ry, rw, rh, a, b;
        bit hit;
        logic [23:0] din, o;
        beat_t e;
        din = s_axis_tdata;
        if (s_axis_tuser) begin
            sh0 = obj_reg0; sh1 = obj_reg1; sh2 = obj_reg2; sh3 = obj_reg3;
            cx = 0; cy = 0;
        end else begin
            cx = mx; cy = my;
        end
        rx = int'(sh0 & 32'hFFF);
        ry = int'((sh0 >> 16) & 32'hFFF);
        rw = int'(sh1 & 32'hFFF);
        rh = int'((sh1 >> 16) & 32'hFFF);
        hit = sh3[0] && cx >= rx && cx < rx + rw && cy >= ry && cy < ry + rh;
        o = din;
        if (hit && !sh3[1]) o = sh2[23:0];
        if (hit && sh3[1]) begin
            for (int ch = 0; ch < 3; ch++) begin
                a = int'(din[ch*8 +: 8]);
                b = int'(sh2[ch*8 +: 8]);
                o[ch*8 +: 8] = 8'((a + b) / 2);
            end
        end
        if (s_axis_tlast) begin
            mx = 0; my = (cy + 1) % 4096;
        end else begin
            mx = (cx + 1) % 4096; my = cy;
        end
        e.d = o; e.u = s_axis_tuser; e.l = s_axis_tlast; e.acc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic step(output bit accepted);
        beat_t e;
        @(negedge ACLK);
        accepted = 1'b0;
        check("frame_cnt", {16'h0, frame_cnt}, fc);
        if (ARESET) begin
            exp_q.delete();
            fc = 0; sh0 = 0; sh1 = 0; sh2 = 0; sh3 = 0; mx = 0; my = 0;
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("stall_valid", {31'h0, m_axis_tvalid}, 1);
                check("stall_data", {6'h0, m_axis_tdata, m_axis_tuser, m_axis_tlast}, {6'h0, held});
            end
            if (m_axis_tvalid && m_axis_tready) begin
                check("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("tdata", {8'h0, m_axis_tdata}, {8'h0, e.d});
                    check("tuser", {31'h0, m_axis_tuser}, {31'h0, e.u});
                    check("tlast", {31'h0, m_axis_tlast}, {31'h0, e.l});
                    if (strict_lat) check("latency", cyc - e.acc, 2);
                end
                if (m_axis_tdata == count_col) n_col++;
                if (m_axis_tuser) fc = (fc + 1) % 65536;
            end
            held_v = m_axis_tvalid && !m_axis_tready;
            held   = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
            if (s_axis_tvalid && s_axis_tready) begin
                model_accept();
                accepted = 1'b1;
            end
        end
        @(posedge ACLK);
        #1;
        cyc++;
        m_axis_tready = ($urandom_range(99) < rdy_pct);
    endtask

    // mode 0 = ramp, 1 = constant cval, 2 = random; max_beats < 0 sends the whole frame.
    task automatic send_frame(input int w, input int h, input int mode, input logic [23:0] cval,
                              input int bubble_pct, input int max_beats,
                              input int chg_beat, input logic [31:0] chg_val);
        int b = 0, tries;
        bit acc;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (max_beats >= 0 && b >= max_beats) return;
                if (b == chg_beat) obj_reg0 = chg_val;
                if ($urandom_range(99) < bubble_pct) begin
                    s_axis_tvalid = 1'b0;
                    step(acc);
                end
                s_axis_tvalid = 1'b1;
                s_axis_tuser  = (x == 0 && y == 0);
                s_axis_tlast  = (x == w - 1);
                case (mode)
                    0:       s_axis_tdata = {8'(y * 16), 8'(x * 8), 8'(x + y * 8)};
                    1:       s_axis_tdata = cval;
                    default: s_axis_tdata = 24'($urandom);
                endcase
                tries = 0;
                do begin
                    step(acc);
                    tries++;
                end while (!acc && tries < 200);
                if (!acc) check("accept_timeout", tries, 0);
                s_axis_tvalid = 1'b0;
                b++;
            end
        end
    endtask

    task automatic drain();
        int t = 0;
        bit acc;
        s_axis_tvalid = 1'b0;
        while ((exp_q.size() > 0 || m_axis_tvalid) && t < 400) begin
            step(acc);
            t++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        bit acc;
        ARESET = 1'b1;
        obj_reg0 = 0; obj_reg1 = 0; obj_reg2 = 0; obj_reg3 = 0;
        s_axis_tdata = 0; s_axis_tuser = 0; s_axis_tlast = 0; s_axis_tvalid = 0;
        m_axis_tready = 1'b1;
        step(acc);
        step(acc);
        ARESET = 1'b0;
        check("rst_tvalid", {31'h0, m_axis_tvalid}, 0);
        check("rst_tdata", {8'h0, m_axis_tdata}, 0);
        check("rst_frame_cnt", {16'h0, frame_cnt}, 0);
        check("rst_tready", {31'h0, s_axis_tready}, 1);

        // Passthrough with exact 2-cycle latency
        strict_lat = 1'b1;
        send_frame(8, 4, 0, 24'h0, 0, -1, -1, 0);
        drain();
        strict_lat = 1'b0;
        check("pass_frame_cnt", {16'h0, frame_cnt}, 1);

        // Replace
        obj_reg0 = 32'h0001_0002; obj_reg1 = 32'h0002_0003; obj_reg2 = 32'hFF0000; obj_reg3 = 1;
        count_col = 24'hFF0000; n_col = 0;
        send_frame(8, 4, 1, 24'h000000, 0, -1, -1, 0);
        drain();
        check("replace_hits", n_col, 6);

        // Blend
        obj_reg3 = 3; count_col = 24'h8F2030; n_col = 0;
        send_frame(8, 4, 1, 24'h204060, 0, -1, -1, 0);
        drain();
        check("blend_hits", n_col, 6);

        // Shadow timing: origin rewritten mid-frame only takes effect next frame
        obj_reg3 = 1; count_col = 24'hFF0000; n_col = 0;
        send_frame(8, 4, 1, 24'h000000, 0, -1, 10, 32'h0000_0000);
        send_frame(8, 4, 1, 24'h000000, 0, -1, -1, 0);
        drain();
        check("shadow_hits", n_col, 12);

        // Clip at right edge with random backpressure and bubbles
        obj_reg0 = 32'h0000_0006; obj_reg1 = 32'h0004_0005; obj_reg2 = 32'h00FF00; obj_reg3 = 1;
        rdy_pct = 50; count_col = 24'h00FF00; n_col = 0;
        send_frame(8, 4, 2, 24'h0, 25, -1, -1, 0);
        drain();
        check("clip_hits", n_col, 8);

        // One-pixel lines: SOF and EOL on the same beat
        obj_reg0 = 32'h0001_0000; obj_reg1 = 32'h0001_0001; obj_reg2 = 32'h123456; obj_reg3 = 1;
        send_frame(1, 3, 2, 24'h0, 0, -1, -1, 0);
        drain();

        // Random objects and frame sizes
        for (int i = 0; i < 6; i++) begin
            obj_reg0 = {4'h0, 12'($urandom_range(0, 5)), 4'h0, 12'($urandom_range(0, 9))};
            obj_reg1 = {4'h0, 12'($urandom_range(0, 4)), 4'h0, 12'($urandom_range(0, 6))};
            obj_reg2 = $urandom;
            obj_reg3 = $urandom;
            send_frame($urandom_range(1, 10), $urandom_range(1, 5), 2, 24'h0, 20, -1, -1, 0);
        end
        drain();

        // Reset after 10 beats of a frame
        obj_reg0 = 32'h0001_0002; obj_reg1 = 32'h0002_0003; obj_reg2 = 32'hFF0000; obj_reg3 = 1;
        send_frame(8, 4, 1, 24'h000000, 0, 10, -1, 0);
        ARESET = 1'b1;
        s_axis_tvalid = 1'b0;
        step(acc);
        ARESET = 1'b0;
        check("midrst_tvalid", {31'h0, m_axis_tvalid}, 0);
        check("midrst_frame_cnt", {16'h0, frame_cnt}, 0);
        obj_reg3 = 1;
        count_col = 24'hFF0000; n_col = 0;
        send_frame(8, 4, 1, 24'h000000, 10, -1, -1, 0);
        drain();
        check("post_rst_hits", n_col, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
